imm_extend_arbiter: RTL and testbench
=====================================

Name: imm_extend_arbiter

Overview:
Shared immediate-generation unit for the dual-lane decode stage of the out-of-order core. Two decode lanes compete for one immediate extractor/sign-extender. A round-robin arbiter grants one lane per cycle. The granted instruction's immediate (I/S/B/U/J format) is extracted, sign-extended to XLEN, and registered into a single-entry valid/ready output toward rename/dispatch.

Parameters:
XLEN, 64, width of extended immediate.
TAG_W, 6, width of the instruction tag carried alongside each request.

Ports:
clk  input  1  clock, rising edge.
reset_n  input  1  asynchronous, active-low reset.
req0_valid  input  1  lane 0 request valid.
req0_ready  output  1  lane 0 request accepted this cycle.
req0_instr  input  32  lane 0 instruction word.
req0_tag  input  TAG_W  lane 0 tag.
req1_valid  input  1  lane 1 request valid.
req1_ready  output  1  lane 1 request accepted this cycle.
req1_instr  input  32  lane 1 instruction word.
req1_tag  input  TAG_W  lane 1 tag.
out_valid  output  1  output register holds a result.
out_ready  input  1  consumer accepts the result.
out_imm  output  XLEN  sign-extended immediate.
out_tag  output  TAG_W  tag of the result.
out_src  output  1  granting lane (0/1).
out_fmt_err  output  1  opcode has no immediate format.

Behaviour:
- Reset (reset_n low, async): out_valid=0, out_imm=0, out_tag=0, out_src=0, out_fmt_err=0, rr_ptr=0 (lane 0 has priority). Reset mid-transfer discards the held entry. No request is accepted while reset_n is low.
- can_accept = !out_valid | out_ready.
- Grant is combinational. Lane i wins if req_i_valid and (rr_ptr==i or the other lane is not valid).
- reqi_ready = can_accept & wins_i. At most one ready per cycle.
- Handshake on lane i (valid & ready): at the next edge, load the output register with imm, tag, src=i, and fmt_err. Set out_valid=1. Set rr_ptr = 1-i.
- With no grant, rr_ptr holds.
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 per cycle while out_ready=1.
- Drain without refill (out_valid & out_ready and no grant): out_valid goes to 0 next cycle. Data fields hold their last value.
- Backpressure (out_valid & !out_ready): all output fields hold stable. Both ready signals are 0. rr_ptr holds.
- A request may drop valid without penalty. A lane that loses arbitration keeps priority next cycle, so there is no starvation.
- Format decode on instr[6:0]. All formats sign-extend from instr[31] up to bit XLEN-1:
  - I (0000011, 0010011, 0011011, 1100111, 1110011): instr[31:20].
  - S (0100011): {instr[31:25], instr[11:7]}.
  - B (1100011): {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
  - U (0110111, 0010111): {instr[31:12], 12'b0}.
  - J (1101111): {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
  - Other opcodes: imm=0, fmt_err=1. Otherwise fmt_err=0.
- The extractor is pure combinational. The only state is the output register plus rr_ptr.

Test Plan:
- Lane 0 only, instr 0xFFF00093 (addi x1,x0,-1), out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFFFFFFFFFF, out_src=0, out_fmt_err=0.
- Format sweep on lane 1: 0x00812423 (sw, +8) -> out_imm=0x8. 0xFE000EE3 (beq, -4) -> 0xFFFFFFFFFFFFFFFC. 0x800000B7 (lui) -> 0xFFFFFFFF80000000. 0x0000007F -> out_imm=0, out_fmt_err=1.
- Both lanes valid continuously for 4 cycles, out_ready=1, after reset -> grants 0,1,0,1. out_src alternates and tags match.
- Result held with out_ready=0 for 3 cycles while both lanes are valid -> out_* stable, req0_ready=req1_ready=0. Raise out_ready -> the held result drains and the pending lane is granted in the same cycle.
- reset_n pulsed low asynchronously (mid-cycle) while out_valid=1 and lane 1 has priority -> out_valid=0 immediately. After release, a simultaneous request grants lane 0.

Source files
------------

// File: rtl/imm_extend_arbiter.sv
// Shared immediate extractor for two decode lanes: round-robin grant, I/S/B/U/J
// decode with sign-extension to XLEN, and a single-entry valid/ready output register.
module imm_extend_arbiter #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_instr,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_instr,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_src,
    output logic             out_fmt_err
);

    typedef struct packed {
        logic                   err;
        logic signed [XLEN-1:0] imm;
    } ext_t;

    function automatic logic signed [XLEN-1:0] sext(input logic signed [31:0] v);
        return XLEN'(v);
    endfunction

    // Each format is first assembled as a sign-correct 32-bit value, then widened.
    function automatic ext_t extract(input logic [31:0] instr);
        ext_t               e;
        logic signed [31:0] raw;
        raw   = '0;
        e.err = 1'b0;
        case (instr[6:0])
            7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111, 7'b1110011:
                raw = {{20{instr[31]}}, instr[31:20]};
            7'b0100011:
                raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            7'b1100011:
                raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            7'b0110111, 7'b0010111:
                raw = {instr[31:12], 12'b0};
            7'b1101111:
                raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default:
                e.err = 1'b1;
        endcase
        e.imm = sext(raw);
        return e;
    endfunction

    logic             rr_ptr;
    logic             win0, win1;
    logic             can_accept;
    logic             fire;
    logic [31:0]      instr_p0;
    logic [TAG_W-1:0] tag_p0;
    ext_t             ext_p0;

    logic                   vld_p1;
    logic signed [XLEN-1:0] imm_p1;
    logic [TAG_W-1:0]       tag_p1;
    logic                   src_p1;
    logic                   err_p1;

    // ---- stage p0: arbitration and combinational extraction ----
    assign can_accept = !vld_p1 || out_ready;
    assign win0       = req0_valid && (!rr_ptr || !req1_valid);
    assign win1       = req1_valid && (rr_ptr || !req0_valid);
    assign req0_ready = reset_n && can_accept && win0;
    assign req1_ready = reset_n && can_accept && win1;
    assign fire       = req0_ready || req1_ready;
    assign instr_p0   = win1 ? req1_instr : req0_instr;
    assign tag_p0     = win1 ? req1_tag : req0_tag;
    assign ext_p0     = extract(instr_p0);

    // ---- stage p1: output register ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1 <= 1'b0;
            imm_p1 <= '0;
            tag_p1 <= '0;
            src_p1 <= 1'b0;
            err_p1 <= 1'b0;
            rr_ptr <= 1'b0;
        end else if (fire) begin
            vld_p1 <= 1'b1;
            imm_p1 <= ext_p0.imm;
            tag_p1 <= tag_p0;
            src_p1 <= win1;
            err_p1 <= ext_p0.err;
            rr_ptr <= !win1;
        end else if (out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign out_valid   = vld_p1;
    assign out_imm     = imm_p1;
    assign out_tag     = tag_p1;
    assign out_src     = src_p1;
    assign out_fmt_err = err_p1;

endmodule

// File: tb/tb_imm_extend_arbiter.sv
// Directed bench for imm_extend_arbiter: reset, formats, round-robin, backpressure, async reset.
module tb_imm_extend_arbiter;
    localparam int XLEN  = 64;
    localparam int TAG_W = 6;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [31:0]      req0_instr, req1_instr;
    logic [TAG_W-1:0] req0_tag, req1_tag;
    logic             out_valid, out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [TAG_W-1:0] out_tag;
    logic             out_src, out_fmt_err;

    int total = 0;
    int bad   = 0;

    imm_extend_arbiter #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_instr(req0_instr), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_instr(req1_instr), .req1_tag(req1_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm), .out_tag(out_tag),
        .out_src(out_src), .out_fmt_err(out_fmt_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; out_ready = 1'b1;
        req0_valid = 1'b0; req0_instr = '0; req0_tag = '0;
        req1_valid = 1'b0; req1_instr = '0; req1_tag = '0;
        repeat (2) tick();
        req0_valid = 1'b1; req0_instr = 32'hFFF00093;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", out_valid); end
        total++; if (out_imm !== 64'h0) begin bad++; $display("FAIL rst_imm: got %h want 0", out_imm); end
        total++; if (out_tag !== 6'h0) begin bad++; $display("FAIL rst_tag: got %h want 0", out_tag); end
        total++; if (out_src !== 1'b0) begin bad++; $display("FAIL rst_src: got %b want 0", out_src); end
        total++; if (out_fmt_err !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", out_fmt_err); end
        total++; if (req0_ready !== 1'b0) begin bad++; $display("FAIL rst_ready0: got %b want 0", req0_ready); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_noaccept: got %b want 0", out_valid); end
        req0_valid = 1'b0;
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_lane0();
        req0_valid = 1'b1; req0_instr = 32'hFFF00093; req0_tag = 6'h05;
        #1;
        total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL l0_ready0: got %b want 1", req0_ready); end
        total++; if (req1_ready !== 1'b0) begin bad++; $display("FAIL l0_ready1: got %b want 0", req1_ready); end
        tick();
        req0_valid = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL l0_valid: got %b want 1", out_valid); end
        total++; if (out_imm !== 64'hFFFFFFFFFFFFFFFF) begin bad++; $display("FAIL l0_imm: got %h want ffffffffffffffff", out_imm); end
        total++; if (out_src !== 1'b0) begin bad++; $display("FAIL l0_src: got %b want 0", out_src); end
        total++; if (out_tag !== 6'h05) begin bad++; $display("FAIL l0_tag: got %h want 05", out_tag); end
        total++; if (out_fmt_err !== 1'b0) begin bad++; $display("FAIL l0_err: got %b want 0", out_fmt_err); end
    endtask

    task automatic test_formats();
        logic [31:0] fi [5];
        logic [63:0] fe [5];
        logic        ferr [5];
        fi[0] = 32'h00812423; fe[0] = 64'h0000000000000008; ferr[0] = 1'b0;
        fi[1] = 32'hFE000EE3; fe[1] = 64'hFFFFFFFFFFFFFFFC; ferr[1] = 1'b0;
        fi[2] = 32'h800000B7; fe[2] = 64'hFFFFFFFF80000000; ferr[2] = 1'b0;
        fi[3] = 32'hFFDFF06F; fe[3] = 64'hFFFFFFFFFFFFFFFC; ferr[3] = 1'b0;
        fi[4] = 32'h0000007F; fe[4] = 64'h0000000000000000; ferr[4] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            req1_valid = 1'b1; req1_instr = fi[i]; req1_tag = 6'(i + 8);
            #1;
            total++; if (req1_ready !== 1'b1) begin bad++; $display("FAIL fmt%0d_ready: got %b want 1", i, req1_ready); end
            tick();
            total++; if (out_imm !== fe[i]) begin bad++; $display("FAIL fmt%0d_imm: got %h want %h", i, out_imm, fe[i]); end
            total++; if (out_fmt_err !== ferr[i]) begin bad++; $display("FAIL fmt%0d_err: got %b want %b", i, out_fmt_err, ferr[i]); end
            total++; if (out_src !== 1'b1 || out_tag !== 6'(i + 8)) begin bad++; $display("FAIL fmt%0d_srctag: got %b/%h want 1/%h", i, out_src, out_tag, 6'(i + 8)); end
        end
        req1_valid = 1'b0;
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drain_valid: got %b want 0", out_valid); end
        total++; if (out_tag !== 6'h0C || out_fmt_err !== 1'b1) begin bad++; $display("FAIL drain_hold: got %h/%b want 0c/1", out_tag, out_fmt_err); end
    endtask

    task automatic test_round_robin();
        logic [63:0] exp_imm;
        logic [5:0]  exp_tag;
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        tick();
        out_ready = 1'b1;
        req0_valid = 1'b1; req0_instr = 32'h00100093; req0_tag = 6'h10;
        req1_valid = 1'b1; req1_instr = 32'h00200093; req1_tag = 6'h21;
        for (int k = 0; k < 4; k++) begin
            #1;
            total++; if (req0_ready !== ((k % 2) == 0) || req1_ready !== ((k % 2) == 1)) begin
                bad++; $display("FAIL rr%0d_ready: got %b%b want lane %0d", k, req1_ready, req0_ready, k % 2); end
            tick();
            exp_imm = ((k % 2) == 0) ? 64'd1 : 64'd2;
            exp_tag = ((k % 2) == 0) ? 6'h10 : 6'h21;
            total++; if (out_valid !== 1'b1 || out_src !== 1'(k % 2)) begin bad++; $display("FAIL rr%0d_src: got %b/%b want 1/%0d", k, out_valid, out_src, k % 2); end
            total++; if (out_tag !== exp_tag || out_imm !== exp_imm) begin bad++; $display("FAIL rr%0d_data: got %h/%h want %h/%h", k, out_tag, out_imm, exp_tag, exp_imm); end
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin bad++; $display("FAIL bp%0d_ready: got %b%b want 00", c, req1_ready, req0_ready); end
            tick();
            total++; if (out_valid !== 1'b1 || out_src !== 1'b1 || out_tag !== 6'h21 || out_imm !== 64'd2) begin
                bad++; $display("FAIL bp%0d_hold: got %b/%b/%h/%h want 1/1/21/2", c, out_valid, out_src, out_tag, out_imm); end
        end
        out_ready = 1'b1;
        #1;
        total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin bad++; $display("FAIL bp_release_ready: got %b%b want 01", req1_ready, req0_ready); end
        tick();
        total++; if (out_valid !== 1'b1 || out_src !== 1'b0 || out_tag !== 6'h10) begin bad++; $display("FAIL bp_release_out: got %b/%b/%h want 1/0/10", out_valid, out_src, out_tag); end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL arst_valid: got %b want 0", out_valid); end
        total++; if (out_imm !== 64'h0 || out_tag !== 6'h0) begin bad++; $display("FAIL arst_data: got %h/%h want 0/0", out_imm, out_tag); end
        total++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin bad++; $display("FAIL arst_ready: got %b%b want 00", req1_ready, req0_ready); end
        #1;
        reset_n = 1'b1;
        out_ready = 1'b1;
        #1;
        total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin bad++; $display("FAIL arst_prio: got %b%b want 01", req1_ready, req0_ready); end
        tick();
        total++; if (out_valid !== 1'b1 || out_src !== 1'b0 || out_tag !== 6'h10) begin bad++; $display("FAIL arst_grant: got %b/%b/%h want 1/0/10", out_valid, out_src, out_tag); end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        total++; if (out_valid !== 1'b0 || out_tag !== 6'h10) begin bad++; $display("FAIL final_drain: got %b/%h want 0/10", out_valid, out_tag); end
    endtask

    initial begin
        test_reset();
        test_lane0();
        test_formats();
        test_round_robin();
        test_backpressure();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
